// File: rtl/router_pkt_rx.sv
// router_pkt_rx: terminates a router output port; parses header/length/payload into a show-ahead FIFO with skid backpressure.
// Define RXPKT_CHECKSUM_EN to require and verify an XOR trailer flit after the payload.
module router_pkt_rx #(
    parameter int FIFO_DEPTH = 16,
    parameter int SKID       = 4,
    parameter int MAX_LEN    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_rx_d,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    output logic        o_rx_bp,
    output logic [63:0] o_out_d,
    output logic        o_out_valid,
    output logic        o_out_last,
    input  logic        i_out_ready,
    output logic [7:0]  o_hdr_dst,
    output logic [55:0] o_hdr_tag,
    output logic [15:0] o_hdr_len,
    output logic        o_hdr_valid,
    output logic        o_pkt_done,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [31:0] o_pkt_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] THR  = (AW+1)'(FIFO_DEPTH - SKID);
    localparam logic [15:0] MAXL = 16'(MAX_LEN);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAY, S_DROP, S_CHK} state_t;
`ifdef RXPKT_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
    logic [63:0] r_csum;
`else
    localparam state_t S_END = S_IDLE;
    logic        r_zero;
`endif
    state_t       r_state, w_next;
    logic [63:0]  r_hdr;
    logic [15:0]  r_cnt;
    logic         r_bad;
    logic [64:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]  r_mcnt, w_occ, w_occ_nxt;
    logic         w_pop, w_load, w_full, w_wr, w_push, w_last;
    logic         w_hdr, w_len_ok, w_done, w_err;
    logic [2:0]   w_code;

    assign w_pop     = o_out_valid & i_out_ready;
    assign w_load    = (r_mcnt != '0) & (~o_out_valid | w_pop);
    assign w_occ     = r_mcnt + (AW+1)'(o_out_valid);
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign w_full    = (w_occ == FULL) & ~w_pop;
    assign w_push    = w_wr & ~w_full;
    assign w_last    = r_cnt == 16'd1;
    assign w_occ_nxt = w_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_hdr    = 1'b0;
        w_len_ok = 1'b0;
        w_wr     = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_code   = 3'd0;
        if (i_rx_valid) begin
            if (i_rx_sof) begin
                w_hdr  = 1'b1;
                w_next = S_LEN;
                w_err  = (r_state == S_LEN) | (r_state == S_PAY) | (r_state == S_CHK);
                w_code = w_err ? 3'd1 : 3'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_err  = 1'b1;
                        w_code = 3'd2;
                        w_next = S_DROP;
                    end
                    S_LEN: begin
                        w_err    = i_rx_d[15:0] > MAXL;
                        w_code   = w_err ? 3'd3 : 3'd0;
                        w_len_ok = ~w_err;
                        w_next   = w_err ? S_DROP : (i_rx_d[15:0] == 16'd0) ? S_END : S_PAY;
                    end
                    S_PAY: begin
                        w_wr   = 1'b1;
                        w_err  = w_full;
                        w_code = w_full ? 3'd4 : 3'd0;
                        w_next = w_last ? S_END : S_PAY;
`ifndef RXPKT_CHECKSUM_EN
                        w_done = w_last & ~r_bad & ~w_full;
`endif
                    end
`ifdef RXPKT_CHECKSUM_EN
                    S_CHK: begin
                        w_err  = i_rx_d != r_csum;
                        w_code = w_err ? 3'd5 : 3'd0;
                        w_done = ~w_err & ~r_bad;
                        w_next = S_IDLE;
                    end
`endif
                    default: w_next = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= {w_last, i_rx_d};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hdr       <= '0;
            r_cnt       <= '0;
            r_bad       <= 1'b0;
`ifdef RXPKT_CHECKSUM_EN
            r_csum      <= '0;
`else
            r_zero      <= 1'b0;
`endif
            r_wp        <= '0;
            r_rp        <= '0;
            r_mcnt      <= '0;
            o_rx_bp     <= 1'b0;
            o_out_d     <= '0;
            o_out_valid <= 1'b0;
            o_out_last  <= 1'b0;
            o_hdr_dst   <= '0;
            o_hdr_tag   <= '0;
            o_hdr_len   <= '0;
            o_hdr_valid <= 1'b0;
            o_pkt_done  <= 1'b0;
            o_err       <= 1'b0;
            o_err_code  <= '0;
            o_pkt_cnt   <= '0;
        end else begin
            if (w_hdr) r_hdr <= i_rx_d;
            if (w_len_ok) begin
                r_cnt     <= i_rx_d[15:0];
                r_bad     <= 1'b0;
                o_hdr_dst <= r_hdr[63:56];
                o_hdr_tag <= r_hdr[55:0];
                o_hdr_len <= i_rx_d[15:0];
            end else if (w_wr) begin
                r_cnt <= r_cnt - 16'd1;
                if (w_full) r_bad <= 1'b1;
            end
`ifdef RXPKT_CHECKSUM_EN
            if (w_len_ok) r_csum <= '0;
            else if (w_wr) r_csum <= r_csum ^ i_rx_d;
            o_pkt_done <= w_done;
            if (w_done) o_pkt_cnt <= o_pkt_cnt + 32'd1;
`else
            // zero-length packets complete one cycle after HDR_VALID
            r_zero     <= w_len_ok & (i_rx_d[15:0] == 16'd0);
            o_pkt_done <= w_done | r_zero;
            if (w_done | r_zero) o_pkt_cnt <= o_pkt_cnt + 32'd1;
`endif
            o_hdr_valid <= w_len_ok;
            o_err       <= w_err;
            if (w_err) o_err_code <= w_code;
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_load) begin
                {o_out_last, o_out_d} <= r_mem[r_rp];
                r_rp <= r_rp + AW'(1);
            end
            o_out_valid <= w_load | (o_out_valid & ~w_pop);
            r_mcnt      <= r_mcnt + (AW+1)'(w_push) - (AW+1)'(w_load);
            o_rx_bp     <= w_occ_nxt >= THR;
        end
    end
endmodule

// File: tb/tb_router_pkt_rx.sv
// tb_router_pkt_rx: directed vector table plus hand-written backpressure, overflow, reset and checksum sequences.
module tb_router_pkt_rx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rx_d;
    logic        rx_valid, rx_sof, rx_bp;
    logic [63:0] out_d;
    logic        out_valid, out_last, out_ready;
    logic [7:0]  hdr_dst;
    logic [55:0] hdr_tag;
    logic [15:0] hdr_len;
    logic        hdr_valid, pkt_done, err;
    logic [2:0]  err_code;
    logic [31:0] pkt_cnt;

    router_pkt_rx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_d(rx_d), .i_rx_valid(rx_valid), .i_rx_sof(rx_sof),
        .o_rx_bp(rx_bp), .o_out_d(out_d), .o_out_valid(out_valid), .o_out_last(out_last),
        .i_out_ready(out_ready), .o_hdr_dst(hdr_dst), .o_hdr_tag(hdr_tag), .o_hdr_len(hdr_len),
        .o_hdr_valid(hdr_valid), .o_pkt_done(pkt_done), .o_err(err), .o_err_code(err_code),
        .o_pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, sof;
        logic [63:0] d;
        logic        hv, pd, er;
        logic [2:0]  ec;
        logic        ov;
        logic [63:0] od;
        logic        ol;
        logic [7:0]  dst;
        logic [15:0] len;
        logic [31:0] cnt;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0, n_bad = 0;
    int          n_err4 = 0, n_err5 = 0, n_done = 0;
    logic [7:0]  e_dst = 0;
    logic [15:0] e_len = 0;
    logic [31:0] e_cnt = 0;
    logic [2:0]  e_code = 0;

    always @(negedge clk) begin
        if (err && err_code == 3'd4) n_err4++;
        if (err && err_code == 3'd5) n_err5++;
        if (pkt_done) n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [191:0] all_out();
        return {7'b0, rx_bp, out_d, out_valid, out_last, hdr_dst, hdr_tag, hdr_len,
                hdr_valid, pkt_done, err, err_code, pkt_cnt};
    endfunction

    task automatic add(input logic v, sof, input logic [63:0] d, input logic hv, pd, er, ov,
                       input logic [63:0] od, input logic ol);
        tbl.push_back('{v:v, sof:sof, d:d, hv:hv, pd:pd, er:er, ec:e_code, ov:ov, od:od, ol:ol,
                        dst:e_dst, len:e_len, cnt:e_cnt});
    endtask

    task automatic drive(input logic v, s, input logic [63:0] d);
        rx_valid = v;
        rx_sof   = s;
        rx_d     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [63:0] hdr, input int len, input logic [63:0] base,
                            input int bp_lo, input int bp_hi);
        logic [63:0] x = '0;
        drive(1, 1, hdr);
        drive(1, 0, 64'(len));
        for (int k = 1; k <= len; k++) begin
            drive(1, 0, base + 64'(k - 1));
            x ^= base + 64'(k - 1);
            if (k == bp_lo) chk("bp_below_threshold", {191'b0, rx_bp}, 192'd0);
            if (k == bp_hi) chk("bp_at_threshold", {191'b0, rx_bp}, 192'd1);
        end
`ifdef RXPKT_CHECKSUM_EN
        drive(1, 0, x);
`endif
        drive(0, 0, 0);
    endtask

    task automatic drain(input int n, input logic [63:0] base, input bit want_last);
        int k = 0;
        int cyc = 0;
        out_ready = 1'b1;
        while (k < n && cyc < 200) begin
            if (out_valid) begin
                chk($sformatf("drain_word%0d", k), {127'b0, out_last, out_d},
                    {127'b0, want_last && (k == n - 1), base + 64'(k)});
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (k < n) chk("drain_timeout", 192'(k), 192'(n));
        chk("drain_empty", {191'b0, out_valid}, 192'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int d0, e0;
        rst_n = 0; rx_valid = 0; rx_sof = 0; rx_d = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 192'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
`ifndef RXPKT_CHECKSUM_EN
        // basic packet: header {1,1}, length 10, payload 1..10
        add(1, 1, {8'h1, 56'h1}, 0, 0, 0, 0, 0, 0);
        e_dst = 8'h1; e_len = 16'd10;
        add(1, 0, 64'd10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 64'd1, 0, 0, 0, 0, 0, 0);
        for (int k = 2; k <= 10; k++) begin
            if (k == 10) e_cnt = 1;
            add(1, 0, 64'(k), 0, k == 10, 0, 1, 64'(k - 1), 0);
        end
        add(0, 0, 0, 0, 0, 0, 1, 64'd10, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // truncated after 4 words by header {2,7}, length 2, payload A,B
        add(1, 1, {8'h1, 56'h1}, 0, 0, 0, 0, 0, 0);
        add(1, 0, 64'd10, 1, 0, 0, 0, 0, 0);
        add(1, 0, 64'd1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 64'd2, 0, 0, 0, 1, 64'd1, 0);
        add(1, 0, 64'd3, 0, 0, 0, 1, 64'd2, 0);
        add(1, 0, 64'd4, 0, 0, 0, 1, 64'd3, 0);
        e_code = 3'd1;
        add(1, 1, {8'h2, 56'h7}, 0, 0, 1, 1, 64'd4, 0);
        e_dst = 8'h2; e_len = 16'd2;
        add(1, 0, 64'd2, 1, 0, 0, 0, 0, 0);
        add(1, 0, 64'hA, 0, 0, 0, 0, 0, 0);
        e_cnt = 2;
        add(1, 0, 64'hB, 0, 1, 0, 1, 64'hA, 0);
        add(0, 0, 0, 0, 0, 0, 1, 64'hB, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // no-SOF flit in IDLE, then an oversize packet whose payload is discarded
        e_code = 3'd2;
        add(1, 0, 64'd5, 0, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, {8'h3, 56'h9}, 0, 0, 0, 0, 0, 0);
        e_code = 3'd3;
        add(1, 0, 64'd2000, 0, 0, 1, 0, 0, 0);
        add(1, 0, 64'd1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 64'd2, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // zero-length packet
        add(1, 1, {8'h4, 56'h44}, 0, 0, 0, 0, 0, 0);
        e_dst = 8'h4; e_len = 16'd0;
        add(1, 0, 64'd0, 1, 0, 0, 0, 0, 0);
        e_cnt = 3;
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].sof, tbl[i].d);
            chk($sformatf("vec%0d", i),
                {64'b0, hdr_valid, pkt_done, err, err_code, out_valid, out_valid ? out_d : 64'd0,
                 out_valid & out_last, hdr_dst, hdr_len, pkt_cnt},
                {64'b0, tbl[i].hv, tbl[i].pd, tbl[i].er, tbl[i].ec, tbl[i].ov, tbl[i].od,
                 tbl[i].ol, tbl[i].dst, tbl[i].len, tbl[i].cnt});
        end
        chk("hdr_tag_zero_len", {136'b0, hdr_tag}, {136'b0, 56'h44});
        out_ready = 1'b0;
`endif
        // backpressure: consumer stalled, 14-word packet, router sends SKID words past RX_BP
        d0 = n_done; e0 = n_err4;
        send_pkt({8'h5, 56'h5}, 14, 64'd1, 11, 12);
        chk("bp_no_overflow", 192'(n_err4 - e0), 192'd0);
        chk("bp_pkt_done", 192'(n_done - d0), 192'd1);
        drain(14, 64'd1, 1);
        chk("bp_release", {191'b0, rx_bp}, 192'd0);
        // overflow: 18 words into 16 entries, last two dropped
        d0 = n_done; e0 = n_err4;
        send_pkt({8'h6, 56'h6}, 18, 64'h100, 11, 12);
        chk("ovf_err4_count", 192'(n_err4 - e0), 192'd2);
        chk("ovf_err_code", {189'b0, err_code}, 192'd4);
        chk("ovf_no_done", 192'(n_done - d0), 192'd0);
        drain(16, 64'h100, 0);
        // reset in the middle of a payload
        drive(1, 1, {8'h7, 56'h7});
        drive(1, 0, 64'd5);
        drive(1, 0, 64'd1);
        drive(1, 0, 64'd2);
        rx_valid = 1'b0;
        chk("pre_reset_valid", {191'b0, out_valid}, 192'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", all_out(), 192'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0);
        chk("post_reset_outputs", all_out(), 192'd0);
        send_pkt({8'h8, 56'h8}, 1, 64'h77, 0, 0);
        drain(1, 64'h77, 1);
        chk("post_reset_cnt", {160'b0, pkt_cnt}, 192'd1);
`ifdef RXPKT_CHECKSUM_EN
        // good trailer (XOR of 1..10 = 0xB), then the same payload with a bad trailer
        d0 = n_done;
        drive(1, 1, {8'h9, 56'h9});
        drive(1, 0, 64'd10);
        for (int k = 1; k <= 10; k++) drive(1, 0, 64'(k));
        drive(1, 0, 64'hB);
        chk("csum_good_done", {191'b0, pkt_done}, 192'd1);
        drive(0, 0, 0);
        drain(10, 64'd1, 1);
        e0 = n_err5;
        drive(1, 1, {8'h9, 56'h9});
        drive(1, 0, 64'd10);
        for (int k = 1; k <= 10; k++) drive(1, 0, 64'(k));
        drive(1, 0, 64'h0);
        chk("csum_bad_err", {188'b0, err, err_code}, {188'b0, 1'b1, 3'd5});
        drive(0, 0, 0);
        chk("csum_bad_count", 192'(n_err5 - e0), 192'd1);
        chk("csum_done_count", 192'(n_done - d0), 192'd1);
        drain(10, 64'd1, 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
